// File: rtl/commit_chk_pkg.sv
// rtl/commit_chk_pkg.sv - shared types for the commit trace checker
package commit_chk_pkg;

    // Record field width; the checker's XLEN parameter must equal this.
    localparam int REC_XLEN = 32;

    typedef enum logic {
        KIND_REG   = 1'b0,
        KIND_STORE = 1'b1
    } commit_kind_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_MISMATCH   = 3'd1,
        ERR_UNEXPECTED = 3'd2,
        ERR_TIMEOUT    = 3'd3,
        ERR_PENDING    = 3'd4
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_e;

    typedef struct packed {
        commit_kind_e        kind;
        logic [REC_XLEN-1:0] pc;
        logic [REC_XLEN-1:0] dest;
        logic [REC_XLEN-1:0] data;
    } commit_rec_t;

endpackage

// File: rtl/commit_fifo.sv
// rtl/commit_fifo.sv - synchronous FIFO of expected commit records
module commit_fifo
    import commit_chk_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  commit_rec_t              wr_rec,
    input  logic                     pop,
    output commit_rec_t              rd_rec,
    output logic [REC_XLEN-1:0]      next_pc,
    output logic [REC_XLEN-1:0]      next_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    commit_rec_t    mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW-1:0]  rd_idx_next;

    // Extra pointer MSB distinguishes full from empty when indices coincide.
    assign count       = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_rec      = mem[rd_ptr[AW-1:0]];
    assign rd_idx_next = rd_ptr[AW-1:0] + 1'b1;
    assign next_pc     = mem[rd_idx_next].pc;
    assign next_data   = mem[rd_idx_next].data;

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_rec;
        end
    end

    // Pointer update; a full FIFO refuses pushes even while popping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/commit_trace_checker.sv
// rtl/commit_trace_checker.sv - in-order retirement checker against a golden trace
module commit_trace_checker
    import commit_chk_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 64,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic             exp_kind,
    input  logic [XLEN-1:0]  exp_pc,
    input  logic [XLEN-1:0]  exp_dest,
    input  logic [XLEN-1:0]  exp_data,
    input  logic             act_valid,
    input  logic             act_kind,
    input  logic [XLEN-1:0]  act_pc,
    input  logic [XLEN-1:0]  act_dest,
    input  logic [XLEN-1:0]  act_data,
    input  logic             halt_in,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] fail_index,
    output logic [XLEN-1:0]  fail_pc,
    output logic [XLEN-1:0]  fail_exp_data,
    output logic [XLEN-1:0]  fail_act_data
);
    localparam int AW   = $clog2(DEPTH);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    chk_state_e      state;
    err_code_e       err_q;
    logic [CNT_W-1:0] commit_idx;
    logic [WD_W-1:0] wd_cnt;

    commit_rec_t     head;
    commit_rec_t     push_rec;
    logic [XLEN-1:0] next_pc, next_data;
    logic            fifo_full, fifo_empty;
    logic [AW:0]     fifo_count;

    logic            in_run, do_push, commit, do_pop;
    logic [XLEN-1:0] exp_data_eff;
    logic            dest_eq, rec_match, cmt_err, wd_hit, pending, new_err;
    err_code_e       new_code;
    logic [XLEN-1:0] cap_pc, cap_exp, cap_act;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_run    = (state == ST_RUN);
    assign exp_ready = !fifo_full && (state == ST_IDLE || state == ST_RUN);
    assign do_push   = exp_valid && exp_ready;
    assign commit    = in_run && act_valid;
    assign do_pop    = commit && !fifo_empty;
    assign push_rec  = '{kind: commit_kind_e'(exp_kind), pc: exp_pc, dest: exp_dest, data: exp_data};

    assign busy     = in_run;
    assign pass     = (state == ST_PASS);
    assign fail     = (state == ST_FAIL);
    assign err_code = err_q;

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .wr_rec    (push_rec),
        .pop       (do_pop),
        .rd_rec    (head),
        .next_pc   (next_pc),
        .next_data (next_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Compare the head record with the commit and classify any error this cycle.
    always_comb begin
        exp_data_eff = (head.kind == KIND_REG && head.dest[4:0] == 5'd0) ? '0 : head.data;
        dest_eq      = (head.kind == KIND_REG) ? (head.dest[4:0] == act_dest[4:0])
                                               : (head.dest == act_dest);
        rec_match    = (head.kind == commit_kind_e'(act_kind)) && (head.pc == act_pc)
                       && dest_eq && (exp_data_eff == act_data);
        cmt_err      = commit && (fifo_empty || !rec_match);
        wd_hit       = in_run && !act_valid && !fifo_empty && (wd_cnt == WD_W'(TIMEOUT - 1));
        // Halt sees the FIFO after this cycle's pop; a same-cycle push does not count.
        pending      = in_run && halt_in && ((fifo_count - {{AW{1'b0}}, do_pop}) != '0);
        new_err      = cmt_err || wd_hit || pending;
        new_code     = ERR_NONE;
        cap_pc       = '0;
        cap_exp      = '0;
        cap_act      = '0;
        if (cmt_err) begin
            new_code = fifo_empty ? ERR_UNEXPECTED : ERR_MISMATCH;
            cap_pc   = act_pc;
            cap_exp  = fifo_empty ? '0 : exp_data_eff;
            cap_act  = act_data;
        end else if (wd_hit) begin
            new_code = ERR_TIMEOUT;
            cap_pc   = head.pc;
            cap_exp  = head.data;
        end else if (pending) begin
            new_code = ERR_PENDING;
            cap_pc   = do_pop ? next_pc : head.pc;
            cap_exp  = do_pop ? next_data : head.data;
        end
    end

    // FSM, counters, watchdog and first-failure capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            err_q         <= ERR_NONE;
            commit_idx    <= '0;
            wd_cnt        <= '0;
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            fail_index    <= '0;
            fail_pc       <= '0;
            fail_exp_data <= '0;
            fail_act_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (start) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (commit) begin
                        commit_idx <= sat_inc(commit_idx);
                        if (cmt_err) mismatch_cnt <= sat_inc(mismatch_cnt);
                        else         match_cnt    <= sat_inc(match_cnt);
                    end
                    if (act_valid || fifo_empty || wd_hit) wd_cnt <= '0;
                    else                                   wd_cnt <= wd_cnt + 1'b1;
                    if (new_err && err_q == ERR_NONE) begin
                        err_q         <= new_code;
                        fail_index    <= commit_idx;
                        fail_pc       <= cap_pc;
                        fail_exp_data <= cap_exp;
                        fail_act_data <= cap_act;
                    end
                    if (halt_in) begin
                        state <= (new_err || err_q != ERR_NONE) ? ST_FAIL : ST_PASS;
                    end else if (new_err && STOP_ON_FAIL) begin
                        state <= ST_FAIL;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
// tb/tb_commit_trace_checker.sv - self-checking bench for commit_trace_checker
module tb_commit_trace_checker;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int MAXC    = 65535;

    typedef struct {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] dest;
        logic [31:0] data;
    } trec_t;

    logic clk = 1'b0;
    logic rst, start, exp_valid, exp_kind, act_valid, act_kind, halt_in;
    logic [31:0] exp_pc, exp_dest, exp_data, act_pc, act_dest, act_data;

    logic        exp_ready [2];
    logic        busy [2];
    logic        pass [2];
    logic        fail [2];
    logic [2:0]  err_code [2];
    logic [15:0] match_cnt [2];
    logic [15:0] mismatch_cnt [2];
    logic [15:0] fail_index [2];
    logic [31:0] fail_pc [2];
    logic [31:0] fail_exp_data [2];
    logic [31:0] fail_act_data [2];

    int checks = 0;
    int errors = 0;

    // model state: 0 idle, 1 run, 2 pass, 3 fail
    int          m_st [2];
    trec_t       mq [2][$];
    int          m_match [2];
    int          m_mis [2];
    int          m_idx [2];
    int          m_wd [2];
    int          m_err [2];
    int          m_fidx [2];
    logic [31:0] m_fpc [2];
    logic [31:0] m_fexp [2];
    logic [31:0] m_fact [2];

    always #5 clk = ~clk;

    // instance 1 stops on first failure, instance 0 keeps checking
    for (genvar g = 0; g < 2; g++) begin : g_dut
        commit_trace_checker #(
            .XLEN(32), .DEPTH(DEPTH), .CNT_W(16), .TIMEOUT(TIMEOUT), .STOP_ON_FAIL(g == 1)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start),
            .exp_valid(exp_valid), .exp_ready(exp_ready[g]), .exp_kind(exp_kind),
            .exp_pc(exp_pc), .exp_dest(exp_dest), .exp_data(exp_data),
            .act_valid(act_valid), .act_kind(act_kind), .act_pc(act_pc),
            .act_dest(act_dest), .act_data(act_data), .halt_in(halt_in),
            .busy(busy[g]), .pass(pass[g]), .fail(fail[g]), .err_code(err_code[g]),
            .match_cnt(match_cnt[g]), .mismatch_cnt(mismatch_cnt[g]),
            .fail_index(fail_index[g]), .fail_pc(fail_pc[g]),
            .fail_exp_data(fail_exp_data[g]), .fail_act_data(fail_act_data[g])
        );
    end

    task automatic chk(input int s, input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, s, obs, expv);
        end
    endtask

    task automatic model_step(input int s);
        trec_t h;
        int e;
        logic [31:0] fpc, fexp, fact, expd;
        bit can_push, was_empty, ok;
        if (rst) begin
            m_st[s] = 0; mq[s].delete();
            m_match[s] = 0; m_mis[s] = 0; m_idx[s] = 0; m_wd[s] = 0; m_err[s] = 0;
            m_fidx[s] = 0; m_fpc[s] = 0; m_fexp[s] = 0; m_fact[s] = 0;
            return;
        end
        can_push = (m_st[s] <= 1) && (mq[s].size() < DEPTH);
        if (m_st[s] == 0) begin
            if (start) m_st[s] = 1;
        end else if (m_st[s] == 1) begin
            e = 0; fpc = 0; fexp = 0; fact = 0;
            was_empty = (mq[s].size() == 0);
            if (act_valid) begin
                if (was_empty) begin
                    e = 2; fpc = act_pc; fact = act_data;
                end else begin
                    h = mq[s].pop_front();
                    expd = (h.kind == 1'b0 && h.dest % 32 == 0) ? 32'd0 : h.data;
                    ok = (h.kind == act_kind) && (h.pc == act_pc) && (expd == act_data) &&
                         (h.kind ? (h.dest == act_dest) : (h.dest % 32 == act_dest % 32));
                    if (!ok) begin e = 1; fpc = act_pc; fexp = expd; fact = act_data; end
                end
            end else if (!was_empty) begin
                m_wd[s]++;
                if (m_wd[s] == TIMEOUT) begin
                    m_wd[s] = 0; e = 3; fpc = mq[s][0].pc; fexp = mq[s][0].data;
                end
            end
            if (act_valid || was_empty) m_wd[s] = 0;
            if (halt_in && e == 0 && mq[s].size() != 0) begin
                e = 4; fpc = mq[s][0].pc; fexp = mq[s][0].data;
            end
            if (e != 0 && m_err[s] == 0) begin
                m_err[s] = e; m_fidx[s] = m_idx[s];
                m_fpc[s] = fpc; m_fexp[s] = fexp; m_fact[s] = fact;
            end
            if (act_valid) begin
                if (m_idx[s] < MAXC) m_idx[s]++;
                if (e == 1 || e == 2) begin if (m_mis[s] < MAXC) m_mis[s]++; end
                else begin if (m_match[s] < MAXC) m_match[s]++; end
            end
            if (halt_in) m_st[s] = (m_err[s] != 0) ? 3 : 2;
            else if (e != 0 && s == 1) m_st[s] = 3;
        end
        if (can_push && exp_valid) mq[s].push_back('{exp_kind, exp_pc, exp_dest, exp_data});
    endtask

    task automatic compare_all(input int s);
        chk(s, "exp_ready", 64'(exp_ready[s]), 64'((m_st[s] <= 1) && (mq[s].size() < DEPTH)));
        chk(s, "busy", 64'(busy[s]), 64'(m_st[s] == 1));
        chk(s, "pass", 64'(pass[s]), 64'(m_st[s] == 2));
        chk(s, "fail", 64'(fail[s]), 64'(m_st[s] == 3));
        chk(s, "err_code", 64'(err_code[s]), 64'(m_err[s]));
        chk(s, "match_cnt", 64'(match_cnt[s]), 64'(m_match[s]));
        chk(s, "mismatch_cnt", 64'(mismatch_cnt[s]), 64'(m_mis[s]));
        chk(s, "fail_index", 64'(fail_index[s]), 64'(m_fidx[s]));
        chk(s, "fail_pc", 64'(fail_pc[s]), 64'(m_fpc[s]));
        chk(s, "fail_exp_data", 64'(fail_exp_data[s]), 64'(m_fexp[s]));
        chk(s, "fail_act_data", 64'(fail_act_data[s]), 64'(m_fact[s]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all(0);
        compare_all(1);
    endtask

    task automatic clr_in();
        rst = 0; start = 0; halt_in = 0; exp_valid = 0; act_valid = 0;
        exp_kind = 0; exp_pc = 0; exp_dest = 0; exp_data = 0;
        act_kind = 0; act_pc = 0; act_dest = 0; act_data = 0;
    endtask

    task automatic do_reset();
        clr_in(); rst = 1; cyc(); rst = 0;
    endtask

    task automatic set_exp(input logic k, input logic [31:0] pc, input logic [31:0] d, input logic [31:0] v);
        exp_valid = 1; exp_kind = k; exp_pc = pc; exp_dest = d; exp_data = v;
    endtask

    task automatic set_act(input logic k, input logic [31:0] pc, input logic [31:0] d, input logic [31:0] v);
        act_valid = 1; act_kind = k; act_pc = pc; act_dest = d; act_data = v;
    endtask

    task automatic rand_exp();
        logic k;
        k = 1'($urandom_range(0, 1));
        set_exp(k, $urandom & 32'hFFFF_FFFC, k ? $urandom : 32'($urandom_range(0, 31)), $urandom);
    endtask

    // correct commit for the current head of the non-stopping model
    task automatic act_from_head();
        trec_t h;
        h = mq[0][0];
        set_act(h.kind, h.pc, h.dest, (h.kind == 1'b0 && h.dest % 32 == 0) ? 32'd0 : h.data);
    endtask

    initial begin
        #2000000;
        $display("FAIL sim_guard observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        clr_in();

        // reset state and a clean three-instruction run
        do_reset();
        chk(1, "rst_err", 64'(err_code[1]), 64'd0);
        chk(1, "rst_ready", 64'(exp_ready[1]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            clr_in(); set_exp(0, 32'(4 * i), 32'(i + 1), 32'(5 + 2 * i)); cyc();
        end
        clr_in(); start = 1; cyc();
        for (int i = 0; i < 3; i++) begin
            clr_in(); set_act(0, 32'(4 * i), 32'(i + 1), 32'(5 + 2 * i)); cyc();
        end
        clr_in(); halt_in = 1; cyc(); clr_in();
        chk(1, "s1_pass", 64'(pass[1]), 64'd1);
        chk(1, "s1_match", 64'(match_cnt[1]), 64'd3);

        // data mismatch on the second commit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            clr_in(); set_exp(0, 32'(4 * i), 32'(i + 1), 32'(5 + 2 * i)); cyc();
        end
        clr_in(); start = 1; cyc();
        clr_in(); set_act(0, 0, 1, 5); cyc();
        clr_in(); set_act(0, 4, 2, 8); cyc();
        chk(1, "s2_fail", 64'(fail[1]), 64'd1);
        chk(1, "s2_err", 64'(err_code[1]), 64'd1);
        chk(1, "s2_index", 64'(fail_index[1]), 64'd1);
        chk(1, "s2_exp", 64'(fail_exp_data[1]), 64'd7);
        chk(1, "s2_act", 64'(fail_act_data[1]), 64'd8);
        clr_in(); set_act(0, 8, 3, 9); cyc(); clr_in();
        chk(1, "s2_frozen_match", 64'(match_cnt[1]), 64'd1);
        chk(0, "s2_cont_match", 64'(match_cnt[0]), 64'd2);

        // commit with empty FIFO while a record is pushed the same cycle
        do_reset();
        clr_in(); start = 1; cyc();
        clr_in(); set_act(0, 32'h100, 5, 32'h55); set_exp(0, 32'h100, 5, 32'h55); cyc();
        chk(1, "s3_err", 64'(err_code[1]), 64'd2);
        chk(0, "s3_err0", 64'(err_code[0]), 64'd2);
        clr_in(); set_act(0, 32'h100, 5, 32'h55); cyc(); clr_in();
        chk(0, "s3_kept_rec", 64'(match_cnt[0]), 64'd1);

        // watchdog boundary
        do_reset();
        clr_in(); set_exp(1, 32'h40, 32'h1000, 32'hAB); cyc();
        clr_in(); start = 1; cyc(); clr_in();
        repeat (TIMEOUT - 1) cyc();
        chk(1, "s4_busy63", 64'(busy[1]), 64'd1);
        cyc();
        chk(1, "s4_fail64", 64'(fail[1]), 64'd1);
        chk(1, "s4_err", 64'(err_code[1]), 64'd3);

        // full FIFO, refused push during pop, wrap-around
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            clr_in(); rand_exp(); cyc();
            if (i == DEPTH - 1) chk(1, "s5_full", 64'(exp_ready[1]), 64'd0);
        end
        clr_in(); start = 1; cyc();
        clr_in(); act_from_head(); rand_exp(); cyc();
        chk(0, "s5_ready_after_pop", 64'(exp_ready[0]), 64'd1);
        for (int i = 0; i < 20; i++) begin
            clr_in(); rand_exp();
            if (mq[0].size() > 0) act_from_head();
            cyc();
        end
        for (int i = 0; i < 2 * DEPTH && mq[0].size() > 0; i++) begin
            clr_in(); act_from_head(); cyc();
        end
        clr_in(); halt_in = 1; cyc(); clr_in();
        chk(0, "s5_pass", 64'(pass[0]), 64'd1);
        chk(0, "s5_nomis", 64'(mismatch_cnt[0]), 64'd0);

        // keep checking after mismatches, halt with one record pending
        do_reset();
        for (int i = 0; i < 6; i++) begin clr_in(); rand_exp(); cyc(); end
        clr_in(); start = 1; cyc();
        for (int i = 0; i < 5; i++) begin
            clr_in(); act_from_head();
            if (i == 1 || i == 3) act_data = act_data ^ 32'd1;
            cyc();
        end
        clr_in(); halt_in = 1; cyc(); clr_in();
        chk(0, "s6_fail", 64'(fail[0]), 64'd1);
        chk(0, "s6_err", 64'(err_code[0]), 64'd1);
        chk(0, "s6_mis", 64'(mismatch_cnt[0]), 64'd2);
        chk(0, "s6_index", 64'(fail_index[0]), 64'd1);

        // reset in the middle of a run with handshakes in flight
        do_reset();
        for (int i = 0; i < 2; i++) begin clr_in(); rand_exp(); cyc(); end
        clr_in(); start = 1; cyc();
        clr_in(); act_from_head(); cyc();
        clr_in(); rand_exp(); set_act(0, 0, 0, 1); rst = 1; cyc(); clr_in();
        chk(0, "s6r_busy", 64'(busy[0]), 64'd0);
        chk(0, "s6r_match", 64'(match_cnt[0]), 64'd0);
        chk(0, "s6r_ready", 64'(exp_ready[0]), 64'd1);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 500; n++) begin
            clr_in();
            rst     = ($urandom_range(0, 59) == 0);
            start   = ($urandom_range(0, 7) == 0);
            halt_in = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 1) == 1) rand_exp();
            if ($urandom_range(0, 2) == 0) begin
                if (mq[0].size() > 0 && $urandom_range(0, 7) != 0) begin
                    act_from_head();
                    if ($urandom_range(0, 9) == 0) begin
                        case ($urandom_range(0, 3))
                            0: act_kind = ~act_kind;
                            1: act_pc   = act_pc + 32'd4;
                            2: act_dest = act_dest ^ 32'd1;
                            default: act_data = act_data + 32'd1;
                        endcase
                    end
                end else begin
                    set_act(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
                end
            end
            cyc();
        end
        clr_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
